// File: rtl/odelay_tap_ctrl.sv
// Tap sequencer for one ODELAYE2 in VARIABLE mode: parks the delay at an absolute
// tap or steps it by one, issuing a single CE pulse per tap with a settle gap.
module odelay_tap_ctrl #(
    parameter int INIT_TAP      = 0,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dly_rdy,
    input  logic       req_valid,
    input  logic [4:0] req_tap,
    output logic       req_ready,
    input  logic       step_up,
    input  logic       step_dn,
    output logic       busy,
    output logic       done,
    output logic [4:0] cur_tap,
    output logic       odly_ce,
    output logic       odly_inc,
    output logic       odly_ld,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_LOAD     = 3'd0,
        S_WAIT_RDY = 3'd1,
        S_IDLE     = 3'd2,
        S_PULSE    = 3'd3,
        S_SETTLE   = 3'd4
    } state_t;

    localparam logic [4:0] INIT_TAP_V  = 5'(INIT_TAP);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    // Handshake: a command is taken on a clk edge where req_ready=1 and either
    // req_valid is high or exactly one of step_up/step_dn is high; nothing is queued.

    state_t     state_q, state_d;
    logic [4:0] cur_q;
    logic [4:0] target_q;
    logic       inc_q;
    logic [7:0] cnt_q;
    logic       done_q;

    logic [4:0] cmd_tap;
    logic       accept;
    logic       settle_last;
    logic       at_target;

    always_comb begin
        cmd_tap = cur_q;
        if (req_valid) begin
            cmd_tap = req_tap;
        end else if (step_up && !step_dn) begin
            cmd_tap = (cur_q == 5'd31) ? cur_q : cur_q + 5'd1;
        end else if (step_dn && !step_up) begin
            cmd_tap = (cur_q == 5'd0) ? cur_q : cur_q - 5'd1;
        end
    end

    assign accept      = (state_q == S_IDLE) && dly_rdy && (req_valid || (step_up != step_dn));
    assign settle_last = (cnt_q == SETTLE_LAST);
    assign at_target   = (cur_q == target_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD:     state_d = S_WAIT_RDY;
            S_WAIT_RDY: if (dly_rdy) state_d = S_IDLE;
            S_IDLE:     if (accept && (cmd_tap != cur_q)) state_d = S_PULSE;
            S_PULSE:    state_d = S_SETTLE;
            S_SETTLE: begin
                // Once the gap has elapsed, a missing RDY parks us here with the
                // counter saturated, so the next tap goes out as soon as RDY returns.
                if (settle_last) begin
                    if (at_target) state_d = S_IDLE;
                    else if (dly_rdy) state_d = S_PULSE;
                end
            end
            default:    state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q    <= INIT_TAP_V;
            target_q <= INIT_TAP_V;
            inc_q    <= 1'b0;
            cnt_q    <= 8'd0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        target_q <= cmd_tap;
                        if (cmd_tap == cur_q) begin
                            done_q <= 1'b1;
                        end else begin
                            inc_q <= (cmd_tap > cur_q);
                        end
                    end
                end
                S_PULSE: begin
                    cur_q <= inc_q ? cur_q + 5'd1 : cur_q - 5'd1;
                    cnt_q <= 8'd0;
                end
                S_SETTLE: begin
                    if (!settle_last) begin
                        cnt_q <= cnt_q + 8'd1;
                    end else if (at_target) begin
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        odly_ld   = (state_q == S_LOAD) && !rst;
        odly_ce   = (state_q == S_PULSE) && !rst;
        odly_inc  = inc_q && !rst;
        req_ready = (state_q == S_IDLE) && dly_rdy && !rst;
        busy      = (state_q != S_IDLE) || rst;
        done      = done_q && !rst;
        cur_tap   = rst ? INIT_TAP_V : cur_q;
        state_dbg = state_q;
    end

endmodule

// File: tb/tb_odelay_tap_ctrl.sv
// Directed bench for odelay_tap_ctrl: moves, saturated steps, priority,
// RDY loss mid-move and reset mid-move, with hand-computed timing.
module tb_odelay_tap_ctrl;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       dly_rdy;
    logic       req_valid;
    logic [4:0] req_tap;
    logic       req_ready;
    logic       step_up;
    logic       step_dn;
    logic       busy;
    logic       done;
    logic [4:0] cur_tap;
    logic       odly_ce;
    logic       odly_inc;
    logic       odly_ld;
    logic [2:0] state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    logic [4:0] exp_q[$];

    odelay_tap_ctrl #(.INIT_TAP(0), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .dly_rdy(dly_rdy),
        .req_valid(req_valid), .req_tap(req_tap), .req_ready(req_ready),
        .step_up(step_up), .step_dn(step_dn),
        .busy(busy), .done(done), .cur_tap(cur_tap),
        .odly_ce(odly_ce), .odly_inc(odly_inc), .odly_ld(odly_ld),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command in an IDLE cycle (cycle 0) and follow it to done.
    task automatic move(input string tag, input bit v, input logic [4:0] tap,
                        input bit up, input bit dn, input bit exp_inc, input int exp_n,
                        input logic [4:0] exp_final, input int exp_done,
                        input int drop_at, input int drop_len);
        int cyc, n_ce, ce_bad, ce_lowrdy, done_cyc;
        exp_q.push_back(exp_final);
        req_valid = v; req_tap = tap; step_up = up; step_dn = dn;
        #1;
        check({tag, "_ready_c0"}, req_ready, 1);
        cyc = 0; n_ce = 0; ce_bad = 0; ce_lowrdy = 0; done_cyc = -1;
        while (done_cyc < 0 && cyc < 400) begin
            tick();
            cyc++;
            req_valid = 0; step_up = 0; step_dn = 0;
            dly_rdy = !(drop_len > 0 && cyc >= drop_at && cyc < drop_at + drop_len);
            #1;
            if (odly_ce) begin
                if (!dly_rdy) ce_lowrdy++;
                if (odly_inc !== exp_inc) ce_bad++;
                if (drop_len == 0 && cyc != 1 + n_ce * (1 + S)) ce_bad++;
                n_ce++;
            end
            if (done) done_cyc = cyc;
        end
        check({tag, "_done_cycle"}, done_cyc, exp_done);
        check({tag, "_ce_count"}, n_ce, exp_n);
        check({tag, "_ce_inc_timing"}, ce_bad, 0);
        check({tag, "_ce_while_rdy_low"}, ce_lowrdy, 0);
        check({tag, "_cur_tap"}, cur_tap, exp_q.pop_front());
        check({tag, "_ready_at_done"}, req_ready, 1);
        check({tag, "_busy_at_done"}, busy, 0);
        tick();
        #1;
        check({tag, "_done_one_cycle"}, done, 0);
    endtask

    // Counts LD pulses and cycles until req_ready after rst falls in the current cycle.
    task automatic release_reset(input string tag);
        int n_ld, n_ce, n_done, ready_cyc;
        rst = 0;
        #1;
        n_ld = odly_ld ? 1 : 0;
        n_ce = 0; n_done = 0; ready_cyc = -1;
        for (int k = 1; k <= 10 && ready_cyc < 0; k++) begin
            tick();
            #1;
            if (odly_ld) n_ld++;
            if (odly_ce) n_ce++;
            if (done) n_done++;
            if (req_ready) ready_cyc = k;
        end
        check({tag, "_ld_pulses"}, n_ld, 1);
        check({tag, "_ready_delay"}, ready_cyc, 2);
        check({tag, "_no_ce"}, n_ce, 0);
        check({tag, "_no_done"}, n_done, 0);
        check({tag, "_cur_tap"}, cur_tap, 0);
    endtask

    initial begin
        rst = 1; dly_rdy = 1; req_valid = 0; req_tap = 0; step_up = 0; step_dn = 0;
        repeat (3) tick();
        #1;
        check("rst_busy", busy, 1);
        check("rst_ready", req_ready, 0);
        check("rst_ld", odly_ld, 0);
        check("rst_ce", odly_ce, 0);
        check("rst_inc", odly_inc, 0);
        check("rst_done", done, 0);
        check("rst_cur_tap", cur_tap, 0);
        release_reset("boot");

        move("to5",       1, 5'd5,  0, 0, 1, 5,  5'd5,  26,  0, 0);
        move("to31",      1, 5'd31, 0, 0, 1, 26, 5'd31, 131, 0, 0);
        move("up_sat31",  0, 5'd0,  1, 0, 1, 0,  5'd31, 1,   0, 0);
        move("to20",      1, 5'd20, 0, 0, 0, 11, 5'd20, 56,  0, 0);
        move("20to3",     1, 5'd3,  0, 0, 0, 17, 5'd3,  86,  0, 0);
        move("to0",       1, 5'd0,  0, 0, 0, 3,  5'd0,  16,  0, 0);
        move("dn_sat0",   0, 5'd0,  0, 1, 0, 0,  5'd0,  1,   0, 0);
        move("to2",       1, 5'd2,  0, 0, 1, 2,  5'd2,  11,  0, 0);
        move("prio_req",  1, 5'd9,  1, 1, 1, 7,  5'd9,  36,  0, 0);

        begin : both_steps
            int n_done, n_ce, n_busy;
            step_up = 1; step_dn = 1;
            #1;
            check("both_ready_c0", req_ready, 1);
            n_done = 0; n_ce = 0; n_busy = 0;
            for (int k = 1; k <= 8; k++) begin
                tick();
                step_up = 0; step_dn = 0;
                #1;
                if (done) n_done++;
                if (odly_ce) n_ce++;
                if (busy) n_busy++;
            end
            check("both_no_done", n_done, 0);
            check("both_no_ce", n_ce, 0);
            check("both_not_busy", n_busy, 0);
            check("both_cur_tap", cur_tap, 9);
        end

        move("step_up",   0, 5'd0,  1, 0, 1, 1,  5'd10, 6,   0, 0);
        move("step_dn",   0, 5'd0,  0, 1, 0, 1,  5'd9,  6,   0, 0);
        move("to3",       1, 5'd3,  0, 0, 0, 6,  5'd3,  31,  0, 0);
        move("rdy_drop",  1, 5'd10, 0, 0, 1, 7,  5'd10, 44,  3, 10);

        begin : reset_mid_move
            int n_done;
            req_valid = 1; req_tap = 5'd20;
            tick();
            req_valid = 0;
            #1;
            check("rmm_pulse_ce", odly_ce, 1);
            #1;
            rst = 1;
            tick();
            #1;
            check("rmm_ce_low", odly_ce, 0);
            check("rmm_busy", busy, 1);
            check("rmm_ready", req_ready, 0);
            check("rmm_cur_tap", cur_tap, 0);
            n_done = done ? 1 : 0;
            tick();
            check("rmm_no_done", n_done, 0);
            release_reset("rmm");
        end

        move("after_rst", 1, 5'd7,  0, 0, 1, 7,  5'd7,  36,  0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/odelay_tap_ctrl.md
# odelay_tap_ctrl

Tap sequencer for one ODELAYE2 in `ODELAY_TYPE("VARIABLE")`, clocked on the same clock as the delay's C pin. It accepts absolute tap targets and single-step commands, then drives CE/INC one tap at a time with a settle gap between taps. It gates all motion on IDELAYCTRL RDY and reports the current tap. It replaces hand-wired `CE(~button)`/`INC(1)` hookups in the iologic tests, so a delay can be swept or parked at a known tap.

## Interface
- INIT_TAP, 0: tap the primitive holds after LD; must equal the ODELAYE2 `ODELAY_VALUE` (0..31).
- SETTLE_CYCLES, 4: idle cycles after each CE pulse before the next pulse or completion; legal range 1..255.
- clk  in  1  delay-control clock; also drives ODELAYE2 C.
- rst  in  1  synchronous, active-high reset.
- dly_rdy  in  1  IDELAYCTRL RDY.
- req_valid  in  1  absolute-target request.
- req_tap  in  5  target tap, 0..31.
- req_ready  out  1  request/step accepted on a clk edge while high.
- step_up  in  1  one-tap increment command, sampled when req_ready=1.
- step_dn  in  1  one-tap decrement command, sampled when req_ready=1.
- busy  out  1  high whenever not in IDLE.
- done  out  1  one-cycle pulse when an accepted command completes.
- cur_tap  out  5  tap currently applied to the primitive.
- odly_ce  out  1  to ODELAYE2 CE.
- odly_inc  out  1  to ODELAYE2 INC.
- odly_ld  out  1  to ODELAYE2 LD.

## Operation
- States: LOAD, WAIT_RDY, IDLE, PULSE, SETTLE.
- Reset (any cycle rst=1, including mid-move):
  - Next state is LOAD.
  - odly_ce=0, odly_inc=0, odly_ld=0, done=0, req_ready=0, busy=1.
  - cur_tap=INIT_TAP; the settle counter clears.
  - Any in-flight target is discarded.
- LOAD: odly_ld=1 for exactly one cycle, then WAIT_RDY.
- WAIT_RDY: stay while dly_rdy=0; go to IDLE when dly_rdy=1.
- IDLE:
  - req_ready = dly_rdy, so it is 0 if RDY drops.
  - Acceptance priority: req_valid > step_up > step_dn.
  - step_up and step_dn high together (no req_valid) is a no-op and is not accepted.
- Target on acceptance:
  - req_valid: req_tap.
  - step_up: cur_tap+1, saturating at 31 (no wrap).
  - step_dn: cur_tap-1, saturating at 0 (no wrap).
- No-op acceptance: if target equals cur_tap (including saturated steps), done pulses the next cycle, no CE is issued, and the block stays IDLE.
- Move:
  - Otherwise go to PULSE with odly_inc latched = (target > cur_tap).
  - Movement is always monotonic toward target and never wraps through 31↔0.
- PULSE:
  - odly_ce=1 for one cycle; odly_inc is held stable across that cycle.
  - cur_tap updates by ±1 at the end of the PULSE cycle.
  - Then SETTLE.
- SETTLE:
  - Count SETTLE_CYCLES cycles with odly_ce=0.
  - Then, if cur_tap == target: done=1 and enter IDLE in the same cycle.
  - Else, if dly_rdy=1: PULSE.
  - Else: hold in SETTLE until dly_rdy=1, then PULSE. No tap is lost.
- Commands arriving while req_ready=0 are ignored, not queued.
- odly_inc: outside PULSE it holds its last value; it is 0 after reset.

## Timing
- The request is accepted on edge E (end of cycle 0).
- For a move of N≥1 taps:
  - odly_ce is high in cycles 1, 1+(1+S), …, 1+(N-1)(1+S), with S=SETTLE_CYCLES.
  - done and req_ready are high in cycle N(1+S)+1.
- No-op acceptance: done is high in cycle 1; req_ready stays high.
- After reset release: odly_ld is high in cycle 1, WAIT_RDY from cycle 2, and req_ready is high at the earliest in cycle 3 (with dly_rdy=1).
- cur_tap always equals INIT_TAP plus the net CE pulses issued since the last LD.
- Throughput: one tap per 1+S cycles; 31 taps with S=4 take 155 cycles.

## Test plan
- Reset release with dly_rdy=1, INIT_TAP=0 → odly_ld pulses exactly one cycle, req_ready rises 2 cycles later, cur_tap=0, no CE.
- req_tap=5 from tap 0, S=4 → exactly 5 CE pulses with INC=1, spaced 5 cycles apart; done in cycle 26; cur_tap=5.
- From tap 31, step_up → done next cycle, no CE, cur_tap=31. From tap 0, step_dn → same, cur_tap=0. From tap 20, req_tap=3 → 17 pulses with INC=0.
- req_valid (req_tap=9), step_up and step_dn all high at once from tap 2 → request wins, 7 increments. step_up+step_dn alone → not accepted, no done.
- dly_rdy deasserted mid-move during SETTLE of tap 3→10 → no CE while low; resumes after RDY returns; final cur_tap=10 with exactly 7 total CE pulses.
- rst asserted during PULSE → CE low the next cycle, LD pulse follows, cur_tap=INIT_TAP, busy=1, done never pulses for the aborted request.
